// File: rtl/div_sequencer.sv
// div_sequencer: restoring shift-subtract divider, one quotient bit per cycle.
// Optional early-out for trivial operands when DIV_EARLY_OUT_EN is defined.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module div_sequencer #(
    parameter int WIDTH     = `DATA_WIDTH,
    parameter int CNT_WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] aOperand,
    input  logic [WIDTH-1:0] bOperand,
    input  logic             unsignedEn,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] divResult,
    output logic [WIDTH-1:0] remResult,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        ITERATE,
        FIXUP,
        DONE
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_quo;
    logic [WIDTH-1:0]     r_absB;
    logic [WIDTH-1:0]     r_rawA;
    logic [WIDTH-1:0]     r_divResult;
    logic [WIDTH-1:0]     r_remResult;
    logic                 r_negQ;
    logic                 r_negR;
    logic                 r_divZero;
    logic                 r_outValid;
    logic [CNT_WIDTH-1:0] r_cnt;

    logic                 w_sgn;
    logic                 w_accept;
    logic                 w_early;
    logic [WIDTH-1:0]     w_absA;
    logic [WIDTH-1:0]     w_absB;
    logic [WIDTH:0]       w_shRem;
    logic [WIDTH:0]       w_trial;

    assign w_sgn    = !unsignedEn;
    assign w_accept = inValid && (r_state == IDLE);
    assign w_absA   = (w_sgn && aOperand[WIDTH-1]) ? -aOperand : aOperand;
    assign w_absB   = (w_sgn && bOperand[WIDTH-1]) ? -bOperand : bOperand;

    // Partial remainder with the next dividend bit shifted in; the extra
    // top bit makes the borrow of the trial subtract visible.
    assign w_shRem  = {r_rem, r_quo[WIDTH-1]};
    assign w_trial  = w_shRem - {1'b0, r_absB};

`ifdef DIV_EARLY_OUT_EN
    assign w_early  = (bOperand == '0) || (w_absA < w_absB);
`else
    assign w_early  = 1'b0;
`endif

    assign inReady   = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign outValid  = r_outValid;
    assign divResult = r_divResult;
    assign remResult = r_remResult;

    // Sequencer: latch operands, iterate, sign-fix, then hold until taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_outValid  <= 1'b0;
            r_divResult <= '0;
            r_remResult <= '0;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_absB      <= '0;
            r_rawA      <= '0;
            r_negQ      <= 1'b0;
            r_negR      <= 1'b0;
            r_divZero   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_absB    <= w_absB;
                        r_rawA    <= aOperand;
                        r_negQ    <= w_sgn && (aOperand[WIDTH-1] ^ bOperand[WIDTH-1]);
                        r_negR    <= w_sgn && aOperand[WIDTH-1];
                        r_divZero <= (bOperand == '0);
                        r_cnt     <= CNT_WIDTH'(WIDTH);
                        if (w_early) begin
                            r_quo   <= '0;
                            r_rem   <= w_absA;
                            r_state <= FIXUP;
                        end else begin
                            r_quo   <= w_absA;
                            r_rem   <= '0;
                            r_state <= ITERATE;
                        end
                    end
                end
                ITERATE: begin
                    if (w_trial[WIDTH]) begin
                        r_rem <= w_shRem[WIDTH-1:0];
                    end else begin
                        r_rem <= w_trial[WIDTH-1:0];
                    end
                    r_quo <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
                    r_cnt <= r_cnt - CNT_WIDTH'(1);
                    if (r_cnt == CNT_WIDTH'(1)) begin
                        r_state <= FIXUP;
                    end
                end
                FIXUP: begin
                    if (r_divZero) begin
                        r_divResult <= '1;
                        r_remResult <= r_rawA;
                    end else begin
                        r_divResult <= r_negQ ? -r_quo : r_quo;
                        r_remResult <= r_negR ? -r_rem : r_rem;
                    end
                    r_state <= DONE;
                end
                DONE: begin
                    if (r_outValid && outReady) begin
                        r_outValid <= 1'b0;
                        r_state    <= IDLE;
                    end else begin
                        r_outValid <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: scoreboard bench for the multi-cycle divider.
// Expected results and latencies come from a behavioural reference model.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [31:0] aOperand = '0;
    logic [31:0] bOperand = '0;
    logic        unsignedEn = 1'b0;
    logic        outValid;
    logic        outReady = 1'b0;
    logic [31:0] divResult;
    logic [31:0] remResult;
    logic        busy;

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } exp_t;

    exp_t scb[$];

    div_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .inValid   (inValid),
        .inReady   (inReady),
        .aOperand  (aOperand),
        .bOperand  (bOperand),
        .unsignedEn(unsignedEn),
        .outValid  (outValid),
        .outReady  (outReady),
        .divResult (divResult),
        .remResult (remResult),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mag(input logic [31:0] v, input logic u);
        return (!u && v[31]) ? -v : v;
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic u);
        exp_t e;
        int   sa;
        int   sbv;
        sa  = a;
        sbv = b;
        if (b == 0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
        end else if (u) begin
            e.q = a / b;
            e.r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = a;
            e.r = 0;
        end else begin
            e.q = sa / sbv;
            e.r = sa % sbv;
        end
`ifdef DIV_EARLY_OUT_EN
        e.lat = (b == 0 || mag(a, u) < mag(b, u)) ? 2 : 34;
`else
        e.lat = 34;
`endif
        return e;
    endfunction

    task automatic accept_only(input logic [31:0] a, input logic [31:0] b,
                               input logic u);
        int n;
        aOperand   = a;
        bOperand   = b;
        unsignedEn = u;
        inValid    = 1'b1;
        n = 0;
        while (!inReady && n < 100) begin
            tick();
            n++;
        end
        chk("accept_wait", 32'(n < 100), 32'd1);
        tick();
        inValid = 1'b0;
        scb.push_back(model(a, b, u));
    endtask

    task automatic collect(input int hold);
        int          lat;
        bit          bad;
        exp_t        e;
        logic [31:0] q0;
        logic [31:0] r0;
        lat = 0;
        bad = 0;
        while (!outValid && lat < 200) begin
            if (inReady || !busy) bad = 1;
            tick();
            lat++;
        end
        if (scb.size() == 0) begin
            chk("scb_empty", 32'd0, 32'd1);
            return;
        end
        e = scb.pop_front();
        chk("latency", lat, e.lat);
        chk("rdy_busy", 32'(bad), 32'd0);
        chk("quo", divResult, e.q);
        chk("rem", remResult, e.r);
        q0  = divResult;
        r0  = remResult;
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            aOperand = $urandom;
            inValid  = i[0];
            tick();
            if (divResult !== q0 || remResult !== r0 || !outValid || inReady)
                bad = 1;
        end
        inValid = 1'b0;
        chk("hold_stable", 32'(bad), 32'd0);
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        chk("post_hs", {29'd0, outValid, inReady, busy}, 32'b010);
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b,
                       input logic u, input int hold);
        accept_only(a, b, u);
        collect(hold);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_flags", {29'd0, outValid, inReady, busy}, 32'b010);
        chk("rst_quo", divResult, 32'd0);
        chk("rst_rem", remResult, 32'd0);
        reset = 1'b0;
        tick();

        run(32'hFFFF_FFF9, 32'h2, 1'b0, 0);
        run(32'hFFFF_FFFF, 32'h10, 1'b1, 0);
        run(32'h7, 32'h0, 1'b0, 0);
        run(32'h7, 32'h0, 1'b1, 0);
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        run(32'd12345, 32'hFFFF_FFEF, 1'b0, 5);
        run(32'hFFFF_FFFD, 32'd10, 1'b0, 1);
        run(32'd3, 32'hFFFF_FFF6, 1'b1, 0);

        accept_only(32'd100, 32'd3, 1'b0);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        scb.delete();
        chk("midrst_flags", {29'd0, outValid, inReady, busy}, 32'b010);
        chk("midrst_quo", divResult, 32'd0);
        chk("midrst_rem", remResult, 32'd0);
        run(32'd9, 32'd4, 1'b0, 0);

        for (int k = 0; k < 6; k++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = (k < 3) ? ($urandom >> $urandom_range(0, 28)) : $urandom;
            run(ra, rb, k[0], k % 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
Multi-cycle integer divide unit that replaces the single-cycle combinational divide in the integer ALU. It uses a restoring shift-subtract algorithm and retires one quotient bit per cycle.
- Front end: valid/ready handshake from the execute stage.
- Back end: valid/ready handshake to writeback.
- Handles signed/unsigned DIV and REM with RISC-V result semantics, including divide-by-zero and signed overflow.

Parameters:
- WIDTH, default `DATA_WIDTH (32): operand and result width.
- CNT_WIDTH, default 6: iteration counter width. Must satisfy 2^CNT_WIDTH > WIDTH.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- inValid  in  1  request valid.
- inReady  out  1  unit can accept a request.
- aOperand  in  WIDTH  dividend.
- bOperand  in  WIDTH  divisor.
- unsignedEn  in  1  1 = unsigned operation, 0 = signed.
- outValid  out  1  result valid.
- outReady  in  1  consumer accepts the result.
- divResult  out  WIDTH  quotient.
- remResult  out  WIDTH  remainder.
- busy  out  1  unit is in any state other than IDLE.

Behaviour:
- States: IDLE, ITERATE, FIXUP, DONE. One-hot or binary encoding, implementer's choice.
- Reset (synchronous, active-high): state=IDLE; outValid=0; divResult=0; remResult=0; counter=0; busy=0. Reset mid-operation discards the operation; no output is produced.
- inReady = (state==IDLE). It is combinational from state only and has no dependence on outValid.
- Accept condition: inValid && inReady at a rising edge (call this cycle C0). At accept the unit latches:
  - |A| and |B|, using two's-complement negation only when signed and the MSB is set;
  - negQ = signed && (A.msb ^ B.msb);
  - negR = signed && A.msb;
  - divZero = (B==0);
  - the raw aOperand.
- Acceptance also clears the partial remainder, loads the quotient register with |A|, and sets counter=WIDTH.
- ITERATE, one bit per cycle:
  - shift {rem,quo} left by 1;
  - trial = rem - |B|, computed in WIDTH+1 bits;
  - if trial is non-negative, rem = trial and quo[0] = 1, else quo[0] = 0;
  - decrement counter; leave for FIXUP when counter reaches 1 on the current cycle.
- ITERATE occupies cycles C1..C(WIDTH).
- FIXUP, cycle C(WIDTH+1):
  - divResult = negQ ? -quo : quo;
  - remResult = negR ? -rem : rem;
  - divZero overrides both: divResult = all ones, remResult = the latched raw aOperand. This applies to both signed and unsigned operations.
  - Signed overflow (0x80000000 / -1) needs no special case: the natural result is q=0x80000000, r=0.
- DONE: outValid=1 starting at cycle C(WIDTH+2). Baseline latency is WIDTH+2 cycles (34 for WIDTH=32).
  - divResult and remResult are held stable while outValid && !outReady.
  - outValid && outReady: next state = IDLE, outValid=0. The next request can be accepted no earlier than the cycle after return to IDLE; there is no same-cycle turnaround.
- Input changes while not in IDLE are ignored. Operands are used only as latched at accept.
- Widths: all negation is modulo 2^WIDTH. The trial subtract is WIDTH+1 bits so the borrow is visible.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN
- Defined: at accept, if divZero, or if |A| < |B| (unsigned magnitude compare), the unit skips ITERATE and goes directly to FIXUP with quo=0 and rem=|A|. The divZero override still applies. outValid rises at C2.
- Undefined: every operation takes the full WIDTH+2 cycles. Results are identical in both builds; only latency differs.

Test Plan:
- Signed -7 / 2 (0xFFFFFFF9, 0x2, unsignedEn=0) -> divResult=0xFFFFFFFD, remResult=0xFFFFFFFF; outValid exactly 34 cycles after accept.
- Unsigned 0xFFFFFFFF / 0x10 -> divResult=0x0FFFFFFF, remResult=0x0000000F; inReady=0 and busy=1 throughout.
- Divide by zero, signed 7 / 0 -> divResult=0xFFFFFFFF, remResult=0x00000007. With DIV_EARLY_OUT_EN, outValid at C2; without it, at C34.
- Overflow 0x80000000 / 0xFFFFFFFF signed -> divResult=0x80000000, remResult=0x00000000.
- Backpressure: hold outReady=0 for 5 cycles after outValid, and toggle aOperand/inValid meanwhile -> outputs stable, inReady=0. The next request is accepted only after the outReady handshake and the return to IDLE.
- Reset mid-operation: assert reset at C10 of 100/3 -> next cycle state=IDLE, outValid=0, outputs=0. A new 9/4 request then yields q=2, r=1.
